// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver.
//   rx_state_t      - receiver FSM states
//   PRESC_*         - legal oversampling ratios
//   PAR_EVEN/ODD    - parity-type encodings (same as the transmitter)
//   prescale_legal  - true for a supported oversampling ratio
//   maj3            - 2-of-3 majority vote
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversampling edge counter and frame bit counter.
//   clk, rst   - clock, async active-high reset
//   enable     - advance the counters (receiver busy)
//   clear      - restart at a start-bit detect
//   prescale   - captured oversampling ratio P
//   edge_cnt   - 0 .. P-1 within the current bit
//   bit_cnt    - bit index in the frame (0 = start bit)
//   mid_stb    - high on the three sample edges P/2-1, P/2, P/2+1
//   bit_end    - high on edge P-1
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  mid_stb,
  output logic                  bit_end
);

  localparam logic [PRESCALE_W-1:0] ONE   = 1;
  localparam logic [BIT_W-1:0]      B_ONE = 1;

  logic [PRESCALE_W-1:0] half;

  assign half    = prescale >> 1;
  assign mid_stb = (edge_cnt >= half - ONE) && (edge_cnt <= half + ONE);
  assign bit_end = (edge_cnt == prescale - ONE);

  // The detect cycle itself is edge 0 of the start bit, so a clear loads
  // edge 1 for the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear) begin
      edge_cnt <= ONE;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + B_ONE;
      end else begin
        edge_cnt <= edge_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/uart_rx_top.sv
// uart_rx_top: oversampled UART receiver, 8N1 / 8E1 / 8O1 frames, LSB first.
//   CLK        - oversampling clock, Prescale cycles per bit
//   RST        - async active-high reset
//   RX_IN      - serial line, idles high
//   Prescale   - oversampling ratio (8, 16 or 32), captured at frame start
//   Par_EN     - parity bit present, captured at frame start
//   Par_type   - 0 even, 1 odd, captured at frame start
//   P_Data     - data of the last good frame
//   Data_valid - 1-cycle pulse on a good frame
//   Par_err    - 1-cycle pulse on parity mismatch
//   Stp_err    - 1-cycle pulse on a bad stop bit
module uart_rx_top
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Par_EN,
  input  logic                  Par_type,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  Data_valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 3);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  localparam logic [PRESCALE_W-1:0] TWO       = 2;
  localparam logic [BIT_W-1:0]      B_ONE     = 1;
  localparam logic [BIT_W-1:0]      LAST_DATA = BIT_W'(DATA_WIDTH);

  rx_state_t state, nxt;

  logic                  rx_meta, rx_s;
  logic [PRESCALE_W-1:0] p_q;
  logic                  pe_q, pt_q;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  mid_stb, bit_end, maj_stb;
  logic [2:0]            samp;
  logic                  maj, bit_val;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      data_idx;
  logic                  par_exp, par_bad;
  logic                  start_det, dv_nxt, pe_nxt, se_nxt;

  // Line synchronizer; resets to the idle level so reset never looks
  // like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  uart_rx_edge_bit_counter #(
    .PRESCALE_W(PRESCALE_W),
    .BIT_W     (BIT_W)
  ) u_cnt (
    .clk     (CLK),
    .rst     (RST),
    .enable  (state != IDLE),
    .clear   (state == IDLE),
    .prescale(p_q),
    .edge_cnt(edge_cnt),
    .bit_cnt (bit_cnt),
    .mid_stb (mid_stb),
    .bit_end (bit_end)
  );

  // Majority is complete once the three mid-bit samples are in.
  assign maj_stb  = (edge_cnt == (p_q >> 1) + TWO);
  assign maj      = maj3(samp);
  assign data_idx = IDX_W'(bit_cnt - B_ONE);   // bit_cnt 1 is data bit 0
  assign par_exp  = (^shreg) ^ pt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp    <= '0;
      bit_val <= 1'b0;
    end else begin
      if (mid_stb) samp <= {samp[1:0], rx_s};
      if (maj_stb) bit_val <= maj;
    end
  end

  // Frame config, data shifter and parity flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q     <= '0;
      pe_q    <= 1'b0;
      pt_q    <= 1'b0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      if (start_det) begin
        p_q     <= Prescale;
        pe_q    <= Par_EN;
        pt_q    <= Par_type;
        par_bad <= 1'b0;
      end
      if (state == DATA && maj_stb)   shreg[data_idx] <= maj;
      if (state == PARITY && maj_stb) par_bad <= (maj != par_exp);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  // STOP is judged mid-bit and hands back to IDLE straight away, so the
  // tail of the stop bit overlaps IDLE and a following start bit may
  // arrive up to P/2-3 cycles early without being missed.
  always_comb begin
    nxt       = state;
    start_det = 1'b0;
    dv_nxt    = 1'b0;
    pe_nxt    = 1'b0;
    se_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s && prescale_legal(32'(Prescale))) begin
          start_det = 1'b1;
          nxt       = START;
        end
      end
      START: begin
        if (bit_end) nxt = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == LAST_DATA) nxt = pe_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) nxt = STOP;
      end
      STOP: begin
        if (maj_stb) begin
          nxt    = IDLE;
          se_nxt = !maj;
          pe_nxt = par_bad;
          dv_nxt = maj && !par_bad;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P_Data     <= '0;
      Data_valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;
    end else begin
      Data_valid <= dv_nxt;
      Par_err    <= pe_nxt;
      Stp_err    <= se_nxt;
      if (dv_nxt) P_Data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed frames with hand-computed results for uart_rx_top.
module tb_uart_rx_top;
  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       Par_EN, Par_type;
  logic [7:0] P_Data;
  logic       Data_valid, Par_err, Stp_err;

  uart_rx_top #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .Par_EN    (Par_EN),
    .Par_type  (Par_type),
    .P_Data    (P_Data),
    .Data_valid(Data_valid),
    .Par_err   (Par_err),
    .Stp_err   (Stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: counts every high-sampled cycle, so a 2-cycle pulse
  // shows up as two.
  int         dv_n = 0, pe_n = 0, se_n = 0;
  int         dv_cyc = 0, dv_prev_cyc = 0;
  logic [7:0] dv_data = 8'h00, dv_prev_data = 8'h00;
  always @(negedge CLK) begin
    if (Data_valid) begin
      dv_n         <= dv_n + 1;
      dv_prev_cyc  <= dv_cyc;
      dv_cyc       <= cyc;
      dv_prev_data <= dv_data;
      dv_data      <= P_Data;
    end
    if (Par_err) pe_n <= pe_n + 1;
    if (Stp_err) se_n <= se_n + 1;
  end

  int n_chk = 0, n_fail = 0;
  int b_dv, b_pe, b_se, t0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_dv = dv_n;
    b_pe = pe_n;
    b_se = se_n;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame a cycle at a time. flip inverts a single cycle
  // (frame-relative index); limit > 0 stops driving after that many cycles.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                            input logic pbit, input logic stopb,
                            input int flip, input int limit);
    logic [10:0] fb;
    int nb;
    fb    = '1;
    fb[0] = 1'b0;
    fb[8:1] = d;
    if (pe) begin
      fb[9] = pbit; fb[10] = stopb; nb = 11;
    end else begin
      fb[9] = stopb; nb = 10;
    end
    t0 = cyc;
    for (int i = 0; i < nb * p && (limit == 0 || i < limit); i++) begin
      RX_IN = fb[i / p] ^ (i == flip);
      @(negedge CLK);
    end
    if (limit == 0) RX_IN = 1'b1;
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd16; Par_EN = 1'b0; Par_type = PAR_EVEN;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 32'({P_Data, Data_valid, Par_err, Stp_err}), 32'd0);
    RST = 1'b0;
    idle(4);

    // Good frame, P=16, no parity: pulse 2 sync cycles + 155 after the drop.
    snap();
    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(32);
    chk("np_dv_count", dv_n - b_dv, 1);
    chk("np_data", 32'(dv_data), 32'hA5);
    chk("np_latency", dv_cyc - t0, 157);
    chk("np_no_err", (pe_n - b_pe) + (se_n - b_se), 0);

    // Parity, P=8: pulse at 2 + 10*8 + 4 + 3 = 89 after the drop.
    Prescale = 6'd8; Par_EN = 1'b1; Par_type = PAR_EVEN;
    snap();
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, -1, 0);
    idle(16);
    chk("even_dv_count", dv_n - b_dv, 1);
    chk("even_data", 32'(dv_data), 32'h3C);
    chk("even_latency", dv_cyc - t0, 89);

    snap();
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, -1, 0);
    idle(16);
    chk("bad_par_err", pe_n - b_pe, 1);
    chk("bad_par_no_dv", (dv_n - b_dv) + (se_n - b_se), 0);
    chk("bad_par_hold", 32'(P_Data), 32'h3C);

    Par_type = PAR_ODD;
    snap();
    send_frame(8'h01, 8, 1'b1, 1'b0, 1'b1, -1, 0);
    idle(16);
    chk("odd_dv_count", dv_n - b_dv, 1);
    chk("odd_data", 32'(dv_data), 32'h01);

    // Stop error, P=32.
    Prescale = 6'd32; Par_EN = 1'b0; Par_type = PAR_EVEN;
    snap();
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, -1, 0);
    idle(96);
    chk("stop_err", se_n - b_se, 1);
    chk("stop_no_dv", dv_n - b_dv, 0);
    chk("stop_no_par", pe_n - b_pe, 0);
    chk("stop_hold", 32'(P_Data), 32'h01);

    // Start glitch of P/2-2 cycles.
    Prescale = 6'd16;
    snap();
    RX_IN = 1'b0;
    repeat (6) @(negedge CLK);
    idle(48);
    chk("glitch_no_pulse", (dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se), 0);
    chk("glitch_idle", 32'(dut.state), 32'(IDLE));

    // One inverted sample at P/2 of data bit 0 is outvoted.
    snap();
    send_frame(8'h96, 16, 1'b0, 1'b0, 1'b1, 16 + 8, 0);
    idle(32);
    chk("vote_dv_count", dv_n - b_dv, 1);
    chk("vote_data", 32'(dv_data), 32'h96);

    // Back-to-back, no gap.
    snap();
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, -1, 0);
    send_frame(8'hAA, 16, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(32);
    chk("b2b_dv_count", dv_n - b_dv, 2);
    chk("b2b_spacing", dv_cyc - dv_prev_cyc, 160);
    chk("b2b_first", 32'(dv_prev_data), 32'h55);
    chk("b2b_second", 32'(dv_data), 32'hAA);

    // Reset during data bit 4 (frame cycles 80..95).
    snap();
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1, -1, 88);
    chk("rst_in_data", 32'(dut.state), 32'(DATA));
    RX_IN = 1'b1;
    RST = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'({P_Data, Data_valid, Par_err, Stp_err}), 32'd0);
    repeat (2) @(negedge CLK);
    chk("rst_mid_idle", 32'(dut.state), 32'(IDLE));
    RST = 1'b0;
    idle(4);
    chk("rst_no_pulse", (dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se), 0);
    snap();
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(32);
    chk("post_rst_dv_count", dv_n - b_dv, 1);
    chk("post_rst_data", 32'(dv_data), 32'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
